// File: rtl/data_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through data cache.
package data_cache_pkg;

    typedef enum logic {IDLE, FILL} cache_state_t;

    localparam int unsigned OffsetBits = 2;

    // Helpers work on a 64-bit zero-extended address so any WIDTH up to 64 fits.
    function automatic logic [63:0] index_of(input logic [63:0] addr, input int unsigned sets);
        return (addr >> OffsetBits) & 64'(sets - 1);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] addr, input int unsigned sets);
        return addr >> (OffsetBits + $clog2(sets));
    endfunction

endpackage

// File: rtl/data_cache_store.sv
// Line storage: valid bits with asynchronous clear, tag and data arrays without reset.
module data_cache_store import data_cache_pkg::*; #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SETS  = 8,
    parameter int unsigned IB    = $clog2(SETS),
    parameter int unsigned TagW  = WIDTH - OffsetBits - IB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IB-1:0]    rd_idx_i,
    output logic             rd_valid_o,
    output logic [TagW-1:0]  rd_tag_o,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [IB-1:0]    wr_idx_i,
    input  logic [TagW-1:0]  wr_tag_i,
    input  logic [WIDTH-1:0] wr_data_i
);

    logic [SETS-1:0]  valid_q;
    logic [TagW-1:0]  tag_q  [SETS];
    logic [WIDTH-1:0] data_q [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate word cache with a two-state read-miss fill.
// Optional read hit/miss counters are built when DATA_CACHE_STATS_EN is defined.
module data_cache import data_cache_pkg::*; #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SETS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Cache_RE,
    input  logic             Cache_WE,
    input  logic [WIDTH-1:0] Cache_addr,
    input  logic [WIDTH-1:0] Cache_WD,
    output logic [WIDTH-1:0] Cache_RD,
    output logic             stall,
    output logic [WIDTH-1:0] Mem_addr,
    output logic             Mem_WE,
    output logic [WIDTH-1:0] Mem_WD,
    input  logic [WIDTH-1:0] Mem_RD,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
);

    localparam int unsigned IB   = $clog2(SETS);
    localparam int unsigned TagW = WIDTH - OffsetBits - IB;

    cache_state_t     state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             retry_q, retry_d;

    logic [IB-1:0]    req_idx, fill_idx, st_wr_idx;
    logic [TagW-1:0]  req_tag, fill_tag, st_wr_tag;
    logic [WIDTH-1:0] st_wr_data, line_data;
    logic [TagW-1:0]  line_tag;
    logic             line_valid, hit, st_we;

    assign req_idx  = IB'(index_of(64'(Cache_addr), SETS));
    assign req_tag  = TagW'(tag_of(64'(Cache_addr), SETS));
    assign fill_idx = IB'(index_of(64'(addr_q), SETS));
    assign fill_tag = TagW'(tag_of(64'(addr_q), SETS));

    data_cache_store #(
        .WIDTH (WIDTH),
        .SETS  (SETS),
        .IB    (IB),
        .TagW  (TagW)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (req_idx),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_en_i    (st_we),
        .wr_idx_i   (st_wr_idx),
        .wr_tag_i   (st_wr_tag),
        .wr_data_i  (st_wr_data)
    );

    assign hit = line_valid && (line_tag == req_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            retry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        // A fill always returns to IDLE, so the flag lives for exactly one IDLE cycle.
        retry_d = (state_q == FILL);
        unique case (state_q)
            IDLE: begin
                if (Cache_RE && !Cache_WE && !hit) begin
                    state_d = FILL;
                    addr_d  = Cache_addr;
                end
            end
            FILL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        Mem_WE     = 1'b0;
        Mem_addr   = {Cache_addr[WIDTH-1:OffsetBits], 2'b00};
        Mem_WD     = Cache_WD;
        Cache_RD   = line_data;
        st_we      = 1'b0;
        st_wr_idx  = req_idx;
        st_wr_tag  = req_tag;
        st_wr_data = Cache_WD;
        unique case (state_q)
            IDLE: begin
                if (Cache_WE) begin
                    Mem_WE = 1'b1;
                    st_we  = hit;
                end else if (Cache_RE && !hit) begin
                    stall = 1'b1;
                end
            end
            FILL: begin
                stall      = 1'b1;
                Mem_addr   = {addr_q[WIDTH-1:OffsetBits], 2'b00};
                st_we      = 1'b1;
                st_wr_idx  = fill_idx;
                st_wr_tag  = fill_tag;
                st_wr_data = Mem_RD;
            end
            default: ;
        endcase
        // Reset is asynchronous, so the outputs must drop without waiting for a clock.
        if (rst) begin
            stall  = 1'b0;
            Mem_WE = 1'b0;
            st_we  = 1'b0;
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_q, miss_q;
    logic        count_hit, count_miss;

    assign count_hit  = (state_q == IDLE) && Cache_RE && !Cache_WE && hit && !retry_q;
    assign count_miss = (state_q == IDLE) && Cache_RE && !Cache_WE && !hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (count_hit)  hit_q  <= hit_q + 32'd1;
            if (count_miss) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed table, reset-during-fill sequence, random traffic.
module tb_data_cache;

    localparam int unsigned SETS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Cache_RE = 1'b0, Cache_WE = 1'b0;
    logic [31:0] Cache_addr = 32'h1000, Cache_WD = '0;
    logic [31:0] Cache_RD, Mem_addr, Mem_WD, Mem_RD, hit_count, miss_count;
    logic        stall, Mem_WE;

    logic [31:0] ram   [1024];
    logic [31:0] ram_m [1024];

    // Reference cache: which word each line holds, plus counters.
    bit          m_valid [SETS];
    int unsigned m_word  [SETS];
    int unsigned m_hits, m_miss;

    int errors = 0, checks = 0;

    data_cache #(.WIDTH(32), .SETS(SETS)) dut (
        .clk        (clk),
        .rst        (rst),
        .Cache_RE   (Cache_RE),
        .Cache_WE   (Cache_WE),
        .Cache_addr (Cache_addr),
        .Cache_WD   (Cache_WD),
        .Cache_RD   (Cache_RD),
        .stall      (stall),
        .Mem_addr   (Mem_addr),
        .Mem_WE     (Mem_WE),
        .Mem_WD     (Mem_WD),
        .Mem_RD     (Mem_RD),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    assign Mem_RD = ram[Mem_addr[11:2]];
    always @(posedge clk) if (Mem_WE) ram[Mem_addr[11:2]] <= Mem_WD;

    function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef DATA_CACHE_STATS_EN
        return 32'(v);
`else
        return 32'd0 & 32'(v);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    // Issue one request at posedge+1 and run it to completion against the model.
    task automatic do_op(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        int unsigned word, idx, n;
        bit          exp_hit;
        word = 32'(addr[11:2]);
        idx  = word % SETS;
        Cache_RE = !we; Cache_WE = we; Cache_addr = addr; Cache_WD = wd;
        #1;
        if (we) begin
            check("st_mem_we", 32'(Mem_WE), 32'd1);
            check("st_mem_addr", Mem_addr, {addr[31:2], 2'b00});
            check("st_mem_wd", Mem_WD, wd);
            check("st_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            ram_m[word] = wd;
        end else begin
            exp_hit = m_valid[idx] && (m_word[idx] == word);
            check("ld_mem_we", 32'(Mem_WE), 32'd0);
            n = 0;
            while (stall && n < 6) begin
                @(posedge clk); #1;
                n++;
            end
            check("ld_stall_cycles", 32'(n), exp_hit ? 32'd0 : 32'd2);
            check("ld_rd", Cache_RD, ram_m[word]);
            @(posedge clk); #1;
            if (exp_hit) m_hits++;
            else begin
                m_miss++;
                m_valid[idx] = 1'b1;
                m_word[idx]  = word;
            end
        end
        Cache_RE = 1'b0; Cache_WE = 1'b0;
        check("hit_count", hit_count, exp_cnt(m_hits));
        check("miss_count", miss_count, exp_cnt(m_miss));
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        int unsigned stalls;
        logic [31:0] rd;
        int unsigned hits;
        int unsigned miss;
    } vec_t;

    vec_t vecs [8];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]   = 32'h5A5A0000 ^ (32'(i) * 32'h01010101);
        end
        ram[0] = 32'hDEADBEEF;
        ram[8] = 32'h0BADF00D;
        for (int i = 0; i < 1024; i++) ram_m[i] = ram[i];
        model_reset();

        vecs[0] = '{0, 32'h1000, 32'h0,        2, 32'hDEADBEEF, 0, 1};
        vecs[1] = '{0, 32'h1000, 32'h0,        0, 32'hDEADBEEF, 1, 1};
        vecs[2] = '{1, 32'h1000, 32'h12345678, 0, 32'h0,        1, 1};
        vecs[3] = '{0, 32'h1000, 32'h0,        0, 32'h12345678, 2, 1};
        vecs[4] = '{1, 32'h1004, 32'hAAAA5555, 0, 32'h0,        2, 1};
        vecs[5] = '{0, 32'h1004, 32'h0,        2, 32'hAAAA5555, 2, 2};
        vecs[6] = '{0, 32'h1020, 32'h0,        2, 32'h0BADF00D, 2, 3};
        vecs[7] = '{0, 32'h1000, 32'h0,        2, 32'h12345678, 2, 4};

        #2;
        check("rst_stall", 32'(stall), 32'd0);
        Cache_WE = 1'b1;
        #1;
        check("rst_mem_we", 32'(Mem_WE), 32'd0);
        Cache_WE = 1'b0;
        check("rst_hits", hit_count, 32'd0);
        check("rst_miss", miss_count, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed table: constants derived by hand from the cache rules.
        for (int i = 0; i < 8; i++) begin
            int unsigned n;
            Cache_RE = !vecs[i].we; Cache_WE = vecs[i].we;
            Cache_addr = vecs[i].addr; Cache_WD = vecs[i].wd;
            #1;
            if (vecs[i].we) begin
                check("tbl_mem_we", 32'(Mem_WE), 32'd1);
                check("tbl_mem_addr", Mem_addr, vecs[i].addr);
                check("tbl_stall", 32'(stall), 32'd0);
            end else begin
                n = 0;
                while (stall && n < 6) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("tbl_stall_cycles", 32'(n), 32'(vecs[i].stalls));
                check("tbl_rd", Cache_RD, vecs[i].rd);
                check("tbl_mem_we", 32'(Mem_WE), 32'd0);
            end
            @(posedge clk); #1;
            Cache_RE = 1'b0; Cache_WE = 1'b0;
            check("tbl_hits", hit_count, exp_cnt(vecs[i].hits));
            check("tbl_miss", miss_count, exp_cnt(vecs[i].miss));
        end

        // Bring the model in line with the table's end state.
        ram_m[0] = 32'h12345678;
        ram_m[1] = 32'hAAAA5555;
        m_valid[0] = 1'b1; m_word[0] = 0;
        m_valid[1] = 1'b1; m_word[1] = 1;
        m_hits = 2; m_miss = 4;

        // Reset asserted mid-fill abandons the fill and invalidates every line.
        Cache_RE = 1'b1; Cache_addr = 32'h1040;
        #1 check("mf_stall_idle", 32'(stall), 32'd1);
        @(posedge clk); #1;
        check("mf_stall_fill", 32'(stall), 32'd1);
        #2 rst = 1'b1;
        #1 check("mf_rst_stall", 32'(stall), 32'd0);
        check("mf_rst_hits", hit_count, 32'd0);
        check("mf_rst_miss", miss_count, 32'd0);
        @(posedge clk); #1;
        Cache_RE = 1'b0;
        rst = 1'b0;
        model_reset();
        do_op(1'b0, 32'h1040, 32'h0);
        do_op(1'b0, 32'h1000, 32'h0);
        do_op(1'b0, 32'h1001, 32'h0);

        // Random traffic over 32 words so lines conflict and hit often.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = 32'h1000 + ($urandom_range(0, 31) * 4) + $urandom_range(0, 3);
            do_op($urandom_range(0, 9) < 3, a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate word cache placed between the CPU memory stage and the byte-addressed data RAM (window 0x0000_1000–0x0000_1FFF). Read hits return data combinationally in the same cycle. Read misses stall the CPU while a two-state fill fetches the word from the RAM. All stores are forwarded to the RAM in the cycle they are issued.

## Interface
Parameters:
- WIDTH, 32, address and data width
- SETS, 8, number of lines (power of two, ≥2); one 32-bit word per line

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- Cache_RE  in  1  CPU load request
- Cache_WE  in  1  CPU store request
- Cache_addr  in  WIDTH  CPU byte address; bits [1:0] ignored (word aligned)
- Cache_WD  in  WIDTH  store data
- Cache_RD  out  WIDTH  load data
- stall  out  1  freeze CPU; request inputs are held stable while high
- Mem_addr  out  WIDTH  RAM address, always word aligned
- Mem_WE  out  1  RAM write enable
- Mem_WD  out  WIDTH  RAM write data
- Mem_RD  in  WIDTH  RAM read data (combinational from Mem_addr)
- hit_count  out  32  read-hit counter
- miss_count  out  32  read-miss counter

## Operation
- Address split: offset [1:0], index [2+IB-1:2] with IB=log2(SETS), tag [WIDTH-1:2+IB].
- Per line: valid bit, tag, data word.
- FSM states: IDLE, FILL.
- IDLE, Cache_WE=1 (takes precedence over Cache_RE): Mem_WE=1, Mem_addr={Cache_addr[31:2],2'b00}, Mem_WD=Cache_WD. On tag hit, line data is updated at the same edge. On miss, the line is untouched (no allocate). stall=0.
- IDLE, Cache_RE=1, Cache_WE=0, hit: Cache_RD = line data, stall=0, hit_count++ unless the retry flag is set.
- IDLE, read miss: stall=1, address latched into addr_q, next state FILL, miss_count++.
- FILL: stall=1, Mem_addr={addr_q[31:2],2'b00}, Mem_WE=0. At the end-of-cycle edge, the line is written with data=Mem_RD, tag, and valid=1. The retry flag is set and the FSM returns to IDLE.
- Retry flag: cleared after the next IDLE cycle. The post-fill hit is not counted as a hit.
- No request in IDLE: stall=0, Mem_WE=0, Cache_RD = data of the indexed line (don't-care to consumers).
- Outside IDLE-write, Mem_addr = current or latched word address, Mem_WD = Cache_WD, and Mem_WE=0.
- Counters wrap at 2^32.

## Timing
- Read hit: 0-cycle latency, combinational.
- Read miss: stall high in cycles N (IDLE) and N+1 (FILL); data valid and stall low in N+2. Miss penalty is 2 cycles.
- Store: RAM and line updated at the posedge ending the request cycle. No stall.
- A store to a line followed by a load in the next cycle hits and returns the new data.
- Reset asserted, asynchronously and at any time:
  - all valid bits 0, state IDLE, retry flag 0, counters 0
  - stall=0, Mem_WE=0 while rst is high
  - A fill in progress is abandoned with no line written.
- Line data and tags are not reset.

## Configuration
- DATA_CACHE_STATS_EN defined: hit_count and miss_count are implemented as described.
- Not defined: no counter registers; both ports are tied to 32'd0. All other behaviour is identical.

## Structure
- data_cache_pkg:
  - state enum cache_state_t {IDLE, FILL}
  - localparams for WIDTH-derived offset bits (2)
  - helper functions for index and tag extraction, parameterised by SETS
- Sub-module data_cache_store: valid/tag/data arrays with an asynchronous valid clear, one combinational read port and one synchronous write port. The top level holds the FSM, hit compare, RAM-side muxing and counters.

## Test plan
- After reset, load 0x1000 (RAM=0xDEADBEEF): stall=1 for 2 cycles, then Cache_RD=0xDEADBEEF with stall=0; miss_count=1, hit_count=0.
- Repeat load 0x1000: stall=0 same cycle, RD=0xDEADBEEF, hit_count=1, Mem_WE=0.
- Store 0x12345678 to 0x1000, then load 0x1000: Mem_WE=1 with Mem_addr=0x1000 in the store cycle; the load hits with 0x12345678 and no stall.
- Store 0xAAAA5555 to 0x1004 (not cached), then load 0x1004: the store does not allocate; the load misses and returns 0xAAAA5555 from the RAM.
- Conflict with SETS=8: load 0x1000 then load 0x1020 (same index): both miss; a following load of 0x1000 misses again; miss_count=3.
- Assert rst during FILL: stall drops immediately, and a subsequent load of the same address misses (valid cleared). Counters are 0, or tied to 0 without DATA_CACHE_STATS_EN.
